// File: rtl/flex_stp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flex_stp_pkg
// Description : Shared definitions for the flexible serial-to-parallel
//               deserialiser: output-side state encoding and default width.
// Revision    : 1.0 - initial release
// ============================================================================
package flex_stp_pkg;

    // Default word width of the deserialiser.
    localparam int c_default_num_bits = 8;

    // Output holding-register state: EMPTY has no unconsumed word,
    // FULL presents a word on data_out with data_valid high.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage : flex_stp_pkg
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Width-parametrised up-counter with programmable rollover.
//               Counts on each enabled cycle; on an enabled cycle at the
//               rollover value it wraps to zero.
// Ports       : clk             - clock, rising edge
//               n_rst           - asynchronous active-low reset
//               i_clear         - synchronous clear to zero
//               i_count_enable  - advance the count this cycle
//               i_rollover_val  - last value before wrapping to zero
//               o_count_out     - current count
//               o_rollover_flag - count currently equals i_rollover_val
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_clear,
    input  logic                    i_count_enable,
    input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
    output logic [NUM_CNT_BITS-1:0] o_count_out,
    output logic                    o_rollover_flag
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    w_at_rollover;

    assign w_at_rollover = (r_count == i_rollover_val);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_enable) begin
            if (w_at_rollover) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count_out     = r_count;
    // Flag is combinational on the current count so the parent can detect
    // a word completion in the same cycle the last bit is sampled.
    assign o_rollover_flag = w_at_rollover;

endmodule : flex_counter
`default_nettype wire

// File: rtl/flex_stp_deser.sv
`default_nettype none
// ============================================================================
// Module      : flex_stp_deser
// Description : Flexible serial-to-parallel deserialiser with a one-word
//               registered output buffer, valid/ready hand-off and a sticky
//               overrun flag for words dropped while the buffer is full.
// Ports       : clk          - clock, rising edge
//               n_rst        - asynchronous active-low reset
//               clear        - synchronous flush of all state
//               shift_enable - sample serial_in this cycle
//               serial_in    - serial data bit
//               data_ready   - consumer accepts data_out this cycle
//               data_out     - registered completed word
//               data_valid   - data_out holds an unconsumed word
//               overrun      - sticky, a completed word was dropped
//               bit_count    - bits accumulated toward the current word
// Revision    : 1.0 - initial release
// ============================================================================
module flex_stp_deser
    import flex_stp_pkg::*;
#(
    parameter int NUM_BITS  = c_default_num_bits,
    parameter int SHIFT_MSB = 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        shift_enable,
    input  logic                        serial_in,
    input  logic                        data_ready,
    output logic [NUM_BITS-1:0]         data_out,
    output logic                        data_valid,
    output logic                        overrun,
    output logic [$clog2(NUM_BITS)-1:0] bit_count
);

    localparam int                   c_cnt_bits = $clog2(NUM_BITS);
    localparam logic [c_cnt_bits-1:0] c_last_bit = c_cnt_bits'(NUM_BITS - 1);

    // ------------------------------------------------------------------------
    // Bit counter
    // ------------------------------------------------------------------------
    logic [c_cnt_bits-1:0] w_bit_count;
    logic                  w_at_last_bit;
    logic                  w_complete;

    flex_counter #(
        .NUM_CNT_BITS (c_cnt_bits)
    ) u_bit_counter (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_clear         (clear),
        .i_count_enable  (shift_enable),
        .i_rollover_val  (c_last_bit),
        .o_count_out     (w_bit_count),
        .o_rollover_flag (w_at_last_bit)
    );

    // A word completes on the edge that samples its last bit.
    assign w_complete = shift_enable & w_at_last_bit;

    // ------------------------------------------------------------------------
    // Assembly register
    // ------------------------------------------------------------------------
    // The completed word is always the stored history plus the bit being
    // sampled now, so only NUM_BITS-1 bits of history need to be kept. The
    // oldest bit is shifted out on the same edge the word is formed.
    logic [NUM_BITS-2:0] r_asm;
    logic [NUM_BITS-1:0] w_word;
    logic [NUM_BITS-2:0] w_asm_next;

    generate
        if (SHIFT_MSB != 0) begin : g_shift_msb
            // LSB-first line: new bit enters at the top, data moves down.
            assign w_word     = {serial_in, r_asm};
            assign w_asm_next = w_word[NUM_BITS-1:1];
        end else begin : g_shift_lsb
            // MSB-first line: new bit enters at the bottom, data moves up.
            assign w_word     = {r_asm, serial_in};
            assign w_asm_next = w_word[NUM_BITS-2:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_asm <= '0;
        end else if (clear) begin
            r_asm <= '0;
        end else if (shift_enable) begin
            // Input side never stalls, whatever the output state.
            r_asm <= w_asm_next;
        end
    end

    // ------------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------------
    out_state_t r_state;
    out_state_t w_next_state;
    logic       w_load;
    logic       w_set_overrun;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_set_overrun = 1'b0;
        if (clear) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    // data_ready is ignored here: nothing to hand over.
                    if (w_complete) begin
                        w_load       = 1'b1;
                        w_next_state = FULL;
                    end
                end
                FULL: begin
                    if (w_complete) begin
                        if (data_ready) begin
                            // Old word leaves as the new one arrives.
                            w_load = 1'b1;
                        end else begin
                            // No room: keep the presented word, drop the new.
                            w_set_overrun = 1'b1;
                        end
                    end else if (data_ready) begin
                        w_next_state = EMPTY;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register and sticky overrun
    // ------------------------------------------------------------------------
    logic [NUM_BITS-1:0] r_data_out;
    logic                r_overrun;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data_out <= '0;
            r_overrun  <= 1'b0;
        end else if (clear) begin
            r_data_out <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out <= w_word;
            end
            if (w_set_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = (r_state == FULL);
    assign overrun    = r_overrun;
    assign bit_count  = w_bit_count;

endmodule : flex_stp_deser
`default_nettype wire

// File: tb/tb_flex_stp_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_stp_deser
// Description : Scoreboard bench for flex_stp_deser. Two instances share the
//               same stimulus: one with MSB entry, one with LSB entry.
//               Expected words are queued when stimulus is issued; a monitor
//               per instance pops and compares each newly presented word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_stp_deser;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       shift_enable;
    logic       serial_in;
    logic       data_ready;

    logic [7:0] dout_m, dout_l;
    logic       dv_m, dv_l;
    logic       ov_m, ov_l;
    logic [2:0] bc_m, bc_l;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    flex_stp_deser #(.NUM_BITS(8), .SHIFT_MSB(1)) dut_m (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .data_ready   (data_ready),
        .data_out     (dout_m),
        .data_valid   (dv_m),
        .overrun      (ov_m),
        .bit_count    (bc_m)
    );

    flex_stp_deser #(.NUM_BITS(8), .SHIFT_MSB(0)) dut_l (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .data_ready   (data_ready),
        .data_out     (dout_l),
        .data_valid   (dv_l),
        .overrun      (ov_l),
        .bit_count    (bc_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitors: a word is "presented" when data_valid rises or data_out
    // changes while valid.
    // ------------------------------------------------------------------------
    logic       pv_m = 1'b0, pv_l = 1'b0;
    logic [7:0] po_m = 8'h00, po_l = 8'h00;

    always @(negedge clk) begin
        logic [7:0] exp;
        if (n_rst === 1'b1 && dv_m === 1'b1 && (pv_m !== 1'b1 || dout_m !== po_m)) begin
            checks++;
            if (q_m.size() == 0) begin
                failures++;
                $display("FAIL word_msb: got %0h expected no word", dout_m);
            end else begin
                exp = q_m.pop_front();
                if (dout_m !== exp) begin
                    failures++;
                    $display("FAIL word_msb: got %0h expected %0h", dout_m, exp);
                end
            end
        end
        pv_m = dv_m;
        po_m = dout_m;
    end

    always @(negedge clk) begin
        logic [7:0] exp;
        if (n_rst === 1'b1 && dv_l === 1'b1 && (pv_l !== 1'b1 || dout_l !== po_l)) begin
            checks++;
            if (q_l.size() == 0) begin
                failures++;
                $display("FAIL word_lsb: got %0h expected no word", dout_l);
            end else begin
                exp = q_l.pop_front();
                if (dout_l !== exp) begin
                    failures++;
                    $display("FAIL word_lsb: got %0h expected %0h", dout_l, exp);
                end
            end
        end
        pv_l = dv_l;
        po_l = dout_l;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. seq[7] is the first bit on the line.
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] seq, input int nbits, input int gap,
                             input bit ready_last, input bit chk_gap);
        for (int i = 0; i < nbits; i++) begin
            shift_enable = 1'b1;
            serial_in    = seq[7-i];
            if (ready_last && i == nbits - 1) data_ready = 1'b1;
            tick();
            shift_enable = 1'b0;
            data_ready   = 1'b0;
            if (chk_gap && i < nbits - 1) begin
                check("gap_valid_low", dv_m, 0);
                check("gap_bit_count", bc_m, i + 1);
            end
            repeat (gap) tick();
        end
    endtask

    task automatic consume();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst        = 1'b0;
        clear        = 1'b0;
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        data_ready   = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_data_out", dout_m, 0);
        check("rst_valid",    dv_m,   0);
        check("rst_overrun",  ov_m,   0);
        check("rst_bit_count", bc_m,  0);
        check("rst_data_out_lsb", dout_l, 0);

        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Bits 1,0,1,0,0,1,1,0: MSB entry -> 0x65, LSB entry -> 0xA6
        q_m.push_back(8'h65);
        q_l.push_back(8'hA6);
        send_bits(8'hA6, 8, 0, 1'b0, 1'b0);
        check("w1_valid",     dv_m, 1);
        check("w1_bit_count", bc_m, 0);
        check("w1_overrun",   ov_m, 0);
        check("w1_valid_lsb", dv_l, 1);

        // Second word while full and not consumed: dropped, overrun set
        send_bits(8'hFF, 8, 0, 1'b0, 1'b0);
        check("ovr_data_held", dout_m, 8'h65);
        check("ovr_flag",      ov_m,   1);
        check("ovr_valid",     dv_m,   1);
        check("ovr_data_held_lsb", dout_l, 8'hA6);
        check("ovr_flag_lsb",  ov_l,   1);

        // Sticky overrun survives idle cycles
        repeat (2) tick();
        check("ovr_sticky", ov_m, 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_data_out",  dout_m, 0);
        check("clr_valid",     dv_m,   0);
        check("clr_overrun",   ov_m,   0);
        check("clr_bit_count", bc_m,   0);
        check("clr_overrun_lsb", ov_l, 0);

        // Transfer coinciding with completion: replace, no overrun
        q_m.push_back(8'h65);
        q_l.push_back(8'hA6);
        send_bits(8'hA6, 8, 0, 1'b0, 1'b0);
        q_m.push_back(8'hFF);
        q_l.push_back(8'hFF);
        send_bits(8'hFF, 8, 0, 1'b1, 1'b0);
        check("xfer_data_out", dout_m, 8'hFF);
        check("xfer_valid",    dv_m,   1);
        check("xfer_overrun",  ov_m,   0);

        // Plain transfer empties the buffer; data_out holds
        consume();
        check("drain_valid",    dv_m,   0);
        check("drain_data_out", dout_m, 8'hFF);

        // data_ready while empty does nothing
        data_ready = 1'b1;
        repeat (2) tick();
        data_ready = 1'b0;
        check("empty_ready_valid",    dv_m,   0);
        check("empty_ready_data_out", dout_m, 8'hFF);

        // Reset mid-word: partial word discarded
        send_bits(8'hA0, 3, 0, 1'b0, 1'b0);
        check("partial_bit_count", bc_m, 3);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_data_out",  dout_m, 0);
        check("async_rst_bit_count", bc_m,   0);
        check("async_rst_valid",     dv_m,   0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check("post_rst_bit_count", bc_m, 0);
        q_m.push_back(8'hC3);
        q_l.push_back(8'hC3);
        send_bits(8'hC3, 8, 0, 1'b0, 1'b0);
        check("post_rst_data_out", dout_m, 8'hC3);
        check("post_rst_valid",    dv_m,   1);
        check("post_rst_bit_count_end", bc_m, 0);
        consume();

        // Gapped enables: 1 on, 2 off
        q_m.push_back(8'h65);
        q_l.push_back(8'hA6);
        send_bits(8'hA6, 8, 2, 1'b0, 1'b1);
        check("gap_valid_final", dv_m,   1);
        check("gap_data_out",    dout_m, 8'h65);
        consume();

        repeat (3) tick();
        check("sb_drained_msb", q_m.size(), 0);
        check("sb_drained_lsb", q_l.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_flex_stp_deser
`default_nettype wire

// File: doc/flex_stp_deser.md
FLEX_STP_DESER -- requirements
Module: flex_stp_deser

Interface
REQ-001 Parameter NUM_BITS, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter SHIFT_MSB, default 1; 1 = new bit enters at MSB (LSB-first line), 0 = new bit enters at LSB (MSB-first line).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush of all state.
REQ-006 shift_enable  input  1  sample serial_in this cycle.
REQ-007 serial_in  input  1  serial data bit.
REQ-008 data_ready  input  1  consumer accepts data_out this cycle.
REQ-009 data_out  output  NUM_BITS  registered completed word.
REQ-010 data_valid  output  1  data_out holds an unconsumed word.
REQ-011 overrun  output  1  sticky: a completed word was dropped.
REQ-012 bit_count  output  $clog2(NUM_BITS)  bits accumulated toward the current word, 0..NUM_BITS-1.

Function
REQ-013 Assembly register shifts one position per cycle with shift_enable=1; the direction follows SHIFT_MSB; the register holds when shift_enable=0.
REQ-014 bit_count increments on each shift_enable; at NUM_BITS-1 with shift_enable it wraps to 0 (word completion).
REQ-015 On completion the word includes the current serial_in and is eligible to load into data_out at that same edge; the load has zero added latency.
REQ-016 Output FSM has two states, EMPTY (data_valid=0) and FULL (data_valid=1).
REQ-017 EMPTY: on completion, load data_out and go to FULL; otherwise hold.
REQ-018 FULL: data_valid=1 and data_ready=1 is a transfer; with no completion that cycle, go to EMPTY; data_out is held.
REQ-019 FULL, transfer and completion in the same cycle: load the new word and stay in FULL; overrun is not set.
REQ-020 FULL, completion with no transfer: drop the new word, keep data_out unchanged, set overrun, stay in FULL.
REQ-021 overrun is cleared only by clear or reset.
REQ-022 data_ready while EMPTY has no effect.
REQ-023 clear has priority over shift_enable, completion and transfer: next state is EMPTY; assembly register, bit_count, data_out and overrun are all zero.
REQ-024 data_out changes only on load, clear or reset.
REQ-025 Assembly continues regardless of output state; the input side is never stalled.

Reset
REQ-026 n_rst low asynchronously forces: data_out=0, data_valid=0, overrun=0, bit_count=0, assembly register=0, FSM=EMPTY.
REQ-027 Reset asserted mid-word discards the partial word; after release, assembly restarts at bit 0.
REQ-028 First active edge after release behaves as a normal cycle.

Structure
REQ-029 Package flex_stp_pkg holds the output-state enum (EMPTY, FULL) and the default width constant.
REQ-030 The bit counter is implemented as sub-module flex_counter, parametrised by width, with a rollover value of NUM_BITS-1 and enabled by shift_enable.
REQ-031 Assembly register, output register and FSM reside in flex_stp_deser.

Verification (NUM_BITS=8 unless noted)
REQ-032 SHIFT_MSB=1, bits 1,0,1,0,0,1,1,0 on 8 consecutive shift_enable cycles, data_ready=0 -> data_valid=1 after 8th edge, data_out=0x65, bit_count=0.
REQ-033 SHIFT_MSB=0, same bit stream -> data_out=0xA6, data_valid=1.
REQ-034 FULL with 0x65, second word 0xFF completes, data_ready=0 -> data_out stays 0x65, overrun=1, data_valid=1; after pulsing clear -> all outputs 0.
REQ-035 FULL with 0x65, data_ready=1 on the cycle the 0xFF word completes -> data_out=0xFF, data_valid=1, overrun=0.
REQ-036 Assert n_rst low after 3 bits, release, then send 8 bits of 0xC3 -> data_out=0xC3, no leakage of the partial word.
REQ-037 shift_enable gapped (1 cycle on, 2 off) over 8 bits -> the same word as gapless; data_valid rises only on the 8th enabled edge.
